// File: rtl/floor_scroller.sv
// Platform manager: scrolls live platforms while the slime is pinned at the ceiling, retires/respawns slots, keeps score.
// Latency 1 cycle from a tick to updated outputs; no backpressure, every tick is consumed.
module floor_scroller #(
  parameter int SPAWN_GAP = 100,
  parameter int BOTTOM    = 479,
  parameter int SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               hit_ceiling,
  input  logic [8:0]         time_gap,
  output logic [9:0]         floor_pos_x0,
  output logic [9:0]         floor_pos_x1,
  output logic [9:0]         floor_pos_x2,
  output logic [9:0]         floor_pos_x3,
  output logic [9:0]         floor_pos_y0,
  output logic [9:0]         floor_pos_y1,
  output logic [9:0]         floor_pos_y2,
  output logic [9:0]         floor_pos_y3,
  output logic [3:0]         enable,
  output logic [SCORE_W-1:0] score
);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  localparam logic [9:0] GAP_Y    = 10'(SPAWN_GAP);
  localparam logic [9:0] BOTTOM_Y = 10'(BOTTOM);
  localparam logic [9:0] SPAWN_X0 = 10'd40;
  localparam logic [9:0] LFSR_RST = 10'h2A5;

  // index 3 first: slot3=(220,80) .. slot0=(300,380)
  localparam slot_t [3:0] SLOT_RST = {
    {10'd220, 10'd80},
    {10'd460, 10'd180},
    {10'd120, 10'd280},
    {10'd300, 10'd380}
  };

  slot_t [3:0]        slot_q, slot_d;
  logic [3:0]         en_q, en_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [9:0]         lfsr_q;

  logic               step;
  logic               free_vld;
  logic [1:0]         free_idx;
  logic               any_live;
  logic [9:0]         min_y;
  logic               gap_ok;
  logic               spawn;

  // Pixel schedule: the slower the jump phase, the sparser the scroll steps.
  always_comb begin
    step = 1'b0;
    if (tick && hit_ceiling) begin
      if (time_gap >= 9'd1 && time_gap < 9'd80)
        step = 1'b1;
      else if (time_gap >= 9'd80 && time_gap < 9'd160)
        step = ~time_gap[0];
      else if (time_gap >= 9'd160 && time_gap < 9'd240)
        step = (time_gap[1:0] == 2'b00);
      else if (time_gap >= 9'd240 && time_gap <= 9'd320)
        step = (time_gap[2:0] == 3'b000);
    end
  end

  always_comb begin
    free_vld = 1'b0;
    free_idx = 2'd0;
    any_live = 1'b0;
    min_y    = 10'h3FF;
    // descending scan so the lowest free index wins
    for (int i = 3; i >= 0; i--) begin
      if (!en_q[i]) begin
        free_vld = 1'b1;
        free_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (en_q[i]) begin
        any_live = 1'b1;
        if (slot_q[i].y < min_y)
          min_y = slot_q[i].y;
      end
    end
  end

  assign gap_ok = !any_live || (min_y >= GAP_Y);
  assign spawn  = tick && free_vld && gap_ok;

  // Scroll decisions use pre-tick enables, so a retiring slot cannot be respawned this tick
  // and a spawning slot (free pre-tick) is never scrolled.
  always_comb begin
    slot_d  = slot_q;
    en_d    = en_q;
    score_d = score_q;
    if (step) begin
      for (int i = 0; i < 4; i++) begin
        if (en_q[i]) begin
          if (slot_q[i].y == BOTTOM_Y)
            en_d[i] = 1'b0;
          else
            slot_d[i].y = slot_q[i].y + 10'd1;
        end
      end
      if (score_q != {SCORE_W{1'b1}})
        score_d = score_q + SCORE_W'(1);
    end
    if (spawn) begin
      slot_d[free_idx].y = 10'd0;
      slot_d[free_idx].x = {1'b0, lfsr_q[8:0]} + SPAWN_X0;
      en_d[free_idx]     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= SLOT_RST;
      en_q    <= 4'b1111;
      score_q <= '0;
    end else if (tick) begin
      slot_q  <= slot_d;
      en_q    <= en_d;
      score_q <= score_d;
    end
  end

  // Free-running x source, maximal-length taps so it never locks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_q <= LFSR_RST;
    else
      lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  assign floor_pos_x0 = slot_q[0].x;
  assign floor_pos_x1 = slot_q[1].x;
  assign floor_pos_x2 = slot_q[2].x;
  assign floor_pos_x3 = slot_q[3].x;
  assign floor_pos_y0 = slot_q[0].y;
  assign floor_pos_y1 = slot_q[1].y;
  assign floor_pos_y2 = slot_q[2].y;
  assign floor_pos_y3 = slot_q[3].y;
  assign enable       = en_q;
  assign score        = score_q;

endmodule

// File: tb/tb_floor_scroller.sv
// Bench for floor_scroller: two instances (default, and wide-gap/4-bit score) against a rule-level model.
module tb_floor_scroller;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       hit_ceiling;
  logic [8:0] time_gap;

  logic [9:0]  ax [4];
  logic [9:0]  ay [4];
  logic [3:0]  en_a;
  logic [15:0] score_a;
  logic [9:0]  bx [4];
  logic [9:0]  by [4];
  logic [3:0]  en_b;
  logic [3:0]  score_b;

  int errors = 0;
  int checks = 0;

  floor_scroller dut_a (
    .clk(clk), .rst(rst), .tick(tick), .hit_ceiling(hit_ceiling), .time_gap(time_gap),
    .floor_pos_x0(ax[0]), .floor_pos_x1(ax[1]), .floor_pos_x2(ax[2]), .floor_pos_x3(ax[3]),
    .floor_pos_y0(ay[0]), .floor_pos_y1(ay[1]), .floor_pos_y2(ay[2]), .floor_pos_y3(ay[3]),
    .enable(en_a), .score(score_a)
  );

  floor_scroller #(.SPAWN_GAP(150), .BOTTOM(479), .SCORE_W(4)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .hit_ceiling(hit_ceiling), .time_gap(time_gap),
    .floor_pos_x0(bx[0]), .floor_pos_x1(bx[1]), .floor_pos_x2(bx[2]), .floor_pos_x3(bx[3]),
    .floor_pos_y0(by[0]), .floor_pos_y1(by[1]), .floor_pos_y2(by[2]), .floor_pos_y3(by[3]),
    .enable(en_b), .score(score_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_x [2][4];
  int m_y [2][4];
  int m_en [2][4];
  int m_score [2];
  int m_lfsr;
  int m_gap [2] = '{100, 150};
  int m_smax [2] = '{65535, 15};

  function automatic bit step_ok(int tg);
    if (tg >= 1 && tg < 80) return 1'b1;
    if (tg >= 80 && tg < 160) return (tg % 2) == 0;
    if (tg >= 160 && tg < 240) return (tg % 4) == 0;
    if (tg >= 240 && tg <= 320) return (tg % 8) == 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    int rx [4] = '{300, 120, 460, 220};
    int ry [4] = '{380, 280, 180, 80};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_x[k][i] = rx[i];
        m_y[k][i] = ry[i];
        m_en[k][i] = 1;
      end
      m_score[k] = 0;
    end
    m_lfsr = 'h2A5;
  endtask

  task automatic model_step(int k);
    int pre_en [4];
    int free;
    int live;
    int min_live;
    bit s;
    s = tick && hit_ceiling && step_ok(int'(time_gap));
    free = -1;
    live = 0;
    min_live = 100000;
    for (int i = 0; i < 4; i++) begin
      pre_en[i] = m_en[k][i];
      if (pre_en[i] == 0 && free < 0) free = i;
      if (pre_en[i] != 0) begin
        live++;
        if (m_y[k][i] < min_live) min_live = m_y[k][i];
      end
    end
    if (s) begin
      for (int i = 0; i < 4; i++)
        if (pre_en[i] != 0) begin
          if (m_y[k][i] == 479) m_en[k][i] = 0;
          else m_y[k][i] = m_y[k][i] + 1;
        end
      if (m_score[k] < m_smax[k]) m_score[k] = m_score[k] + 1;
    end
    if (tick && free >= 0 && (live == 0 || min_live >= m_gap[k])) begin
      m_y[k][free] = 0;
      m_x[k][free] = (m_lfsr % 512) + 40;
      m_en[k][free] = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
      m_lfsr = ((m_lfsr * 2) % 1024) + (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string when);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s a.x%0d", when, i), 32'(ax[i]), m_x[0][i]);
      check($sformatf("%s a.y%0d", when, i), 32'(ay[i]), m_y[0][i]);
      check($sformatf("%s a.en%0d", when, i), 32'(en_a[i]), m_en[0][i]);
      check($sformatf("%s b.x%0d", when, i), 32'(bx[i]), m_x[1][i]);
      check($sformatf("%s b.y%0d", when, i), 32'(by[i]), m_y[1][i]);
      check($sformatf("%s b.en%0d", when, i), 32'(en_b[i]), m_en[1][i]);
    end
    check($sformatf("%s a.score", when), 32'(score_a), m_score[0]);
    check($sformatf("%s b.score", when), 32'(score_b), m_score[1]);
  endtask

  task automatic cycle(input logic t, input logic hc, input logic [8:0] tg, input string tag);
    tick = t;
    hit_ceiling = hc;
    time_gap = tg;
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    tick = 1'b0;
    hit_ceiling = 1'b0;
    time_gap = 9'd0;

    // asynchronous reset, sampled before the first clock edge
    #2 rst = 1'b1;
    #2;
    compare_all("reset_async");
    check("reset y0", 32'(ay[0]), 380);
    check("reset en", 32'(en_a), 15);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 9'd5, "fast");
    check("fast y0", 32'(ay[0]), 390);
    check("fast y3", 32'(ay[3]), 90);
    check("fast x0", 32'(ax[0]), 300);
    check("fast score", 32'(score_a), 10);

    cycle(1'b1, 1'b1, 9'd81, "tg81");
    check("tg81 y0", 32'(ay[0]), 390);
    cycle(1'b1, 1'b1, 9'd82, "tg82");
    check("tg82 y0", 32'(ay[0]), 391);
    cycle(1'b1, 1'b1, 9'd200, "tg200");
    check("tg200 y0", 32'(ay[0]), 392);
    cycle(1'b1, 1'b1, 9'd321, "tg321");
    check("tg321 score", 32'(score_a), 12);
    cycle(1'b1, 1'b1, 9'd0, "tg0");

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 9'd5, "no_ceiling");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 9'd5, "no_tick");
    check("frozen y0", 32'(ay[0]), 392);
    check("frozen score", 32'(score_a), 12);

    // scroll slot0 to the bottom, retire it, respawn it
    n = 0;
    while (m_y[0][0] != 479 && n < 300) begin
      cycle(1'b1, 1'b1, 9'd5, "to_bottom");
      n++;
    end
    check("bottom y0", 32'(ay[0]), 479);
    cycle(1'b1, 1'b1, 9'd5, "retire");
    check("retire en0", 32'(en_a[0]), 0);
    check("retire y0 held", 32'(ay[0]), 479);
    cycle(1'b1, 1'b1, 9'd5, "respawn");
    check("respawn en0", 32'(en_a[0]), 1);
    check("respawn y0", 32'(ay[0]), 0);
    check("respawn x0 range", 32'(ax[0] >= 10'd40 && ax[0] <= 10'd551), 1);
    check("b score saturated", 32'(score_b), 15);

    // wide-gap instance: slot1 retires while slot0 sits near 100, so respawn waits
    n = 0;
    while (m_en[1][1] != 0 && n < 300) begin
      cycle(1'b1, 1'b1, 9'd5, "to_retire1");
      n++;
    end
    check("b retire en1", 32'(en_b[1]), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 9'd5, "gap_block");
      check("gap block en1", 32'(en_b[1]), 0);
    end
    n = 0;
    while (m_en[1][1] == 0 && n < 200) begin
      cycle(1'b1, 1'b1, 9'd5, "gap_wait");
      n++;
    end
    check("gap spawn en1", 32'(en_b[1]), 1);
    check("gap spawn y1", 32'(by[1]), 0);
    check("gap spawn y0", 32'(by[0]), 151);

    // randomized traffic with a mid-run reset pulse
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        rst = 1'b1;
        #2;
        compare_all("rst_mid");
        check("rst_mid y0", 32'(ay[0]), 380);
        check("rst_mid score", 32'(score_a), 0);
        @(negedge clk);
        rst = 1'b0;
      end
      cycle(($urandom % 4) != 0, ($urandom % 8) != 0,
            (($urandom % 10) == 0) ? 9'($urandom % 512) : 9'($urandom_range(0, 330)),
            "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floor_scroller.md
# floor_scroller

Platform manager for the jumper game, sitting on the opposite side of the slime movement logic. It owns the four platform slots and drives each slot's position and enable bit to the movement block. It takes that block's `hit_ceiling` and `time_gap` back. While the slime is pinned at the ceiling, the block scrolls every live platform downward on the same pixel schedule the slime would have risen. It also retires platforms that leave the bottom of the screen, respawns them at the top at a pseudo-random x, and counts scrolled pixels as the score.

## Interface
Parameters:
- `SPAWN_GAP`, default 100: minimum y of the highest live platform before a new one may spawn at y=0.
- `BOTTOM`, default 479: last visible row; a platform scrolled past it is retired.
- `SCORE_W`, default 16: score counter width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle step strobe at the slime update rate; all platform motion happens only on `tick`.
- `hit_ceiling`  in  1  slime is pinned at the ceiling during its rising phase.
- `time_gap`  in  9  slime jump phase counter, 1..321.
- `floor_pos_x0..x3`  out  10 each  left edge of platform slots 0..3 (platforms are 40 px wide).
- `floor_pos_y0..y3`  out  10 each  top row of platform slots 0..3.
- `enable`  out  4  bit i set means slot i is live.
- `score`  out  `SCORE_W`  total pixels scrolled; saturates at all-ones.

## Operation
- All outputs are registered.

Reset values:
- Slots (x,y): 0=(300,380), 1=(120,280), 2=(460,180), 3=(220,80).
- `enable`=4'b1111, `score`=0.
- LFSR=10'h2A5.

Scroll step: on a `tick` with `hit_ceiling`=1, step s∈{0,1} is set by `time_gap`:
- [1,80): s=1.
- [80,160): s=1 iff `time_gap[0]`==0.
- [160,240): s=1 iff `time_gap[1:0]`==0.
- [240,320]: s=1 iff `time_gap[2:0]`==0.
- 0 or >320: s=0.
- When `hit_ceiling`=0 or `tick`=0, s=0.

Scroll effect (when s=1), for each live slot:
- If y==BOTTOM, clear its enable bit and hold y.
- Otherwise y←y+1.
- Disabled slots never move.
- `score`←`score`+1, saturating.

Respawn, evaluated on every `tick` using the pre-tick register state:
- Free slot: the lowest-index slot whose enable bit is 0.
- Gap condition: the minimum y over live slots is ≥ `SPAWN_GAP`, or no slot is live.
- If a free slot exists and the gap condition holds, that slot gets y←0, x←{1'b0,lfsr[8:0]}+40 (range 40..551), enable←1.
- At most one respawn per `tick`.
- A spawned slot is not scrolled on its spawn tick.
- A slot retired on this tick is not reusable until the next `tick`.

LFSR:
- 10-bit Fibonacci, shift left, feedback `lfsr[9]^lfsr[6]`.
- Advances on every `clk`, independent of `tick`; never reaches 0.

Arithmetic: y math is 10-bit unsigned; y never exceeds `BOTTOM`.

## Timing
- Updates occur on the `clk` edge where `tick`=1; new values are visible the following cycle (latency 1).
- Consecutive `tick`s on back-to-back cycles are legal; each is processed independently.
- Inputs are sampled only on `tick`.
- `rst` asserted at any time, including mid-scroll, forces reset values immediately and asynchronously. The first update after release needs a `tick`.
- Simultaneous scroll and respawn on one `tick`:
  - Scroll applies to pre-tick live slots.
  - Respawn targets a pre-tick free slot.
  - Both results are committed together.

## Test plan
- Reset behaviour: assert `rst` → all four slots at the reset coordinates, `enable`=1111, `score`=0, without a clock edge.
- Fast scroll phase: 10 ticks with `hit_ceiling`=1, `time_gap`=5 → every y increases by 10 (slot0 y=390), `score`=10, x unchanged.
- Odd/even gating: one tick with `time_gap`=81 → no change; one tick with `time_gap`=82 → all y +1, `score`+1. Also `time_gap`=200 (low bits 00) → +1, and `time_gap`=321 → no change.
- Retire: scroll until slot0 y=479, then one more scrolling tick → `enable[0]`=0 and y0 holds 479. On the next tick, with slot3 y ≥100 as the minimum live y → slot0 respawns with y=0, x in 40..551, `enable[0]`=1.
- Gap block: slot free but minimum live y=60 → no respawn over repeated ticks until the minimum live y reaches 100; then spawn occurs on that tick.
- No-motion cases:
  - `hit_ceiling`=0 with ticks → positions and score frozen.
  - `hit_ceiling`=1 with `tick`=0 → frozen.
  - `rst` pulse mid-scroll → reset values restored.
- Score saturation: preload `score` near saturation (`SCORE_W`=4) and scroll 20 pixels → `score` stops at 15.
